// File: rtl/z3_slave_decode.sv
// Zorro III slave-cycle front end: strobe sync, address latch/decode, region select, DTACK merge.
// Optional `SLAVE_TIMEOUT_EN` adds a bus-error timeout while waiting for a region acknowledge.
module z3_slave_decode #(
  parameter logic [5:0]  IDREG_MATCH    = 6'b100011,
  parameter logic [3:0]  REG_MATCH      = 4'b1000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FCS_n,
  input  logic [23:0] ADDR,
  input  logic        READ,
  input  logic        configured,
  input  logic [7:0]  bar,
  input  logic        sid_dtack,
  input  logic        scsi_dtack,
  input  logic        reg_dtack,
  output logic        slave_cycle,
  output logic        idreg_region,
  output logic        scsi_region,
  output logic        reg_region,
  output logic        read_lat,
  output logic        DTACK_n,
  output logic        BERR_n
);

  typedef enum logic [2:0] {StIdle, StDecode, StActive, StAck, StWaitEnd} state_e;

  state_e      state_q, state_d;
  logic        fcs_meta_q, fcs_s_q;
  logic [13:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        slave_q, slave_d;
  logic        idreg_q, idreg_d;
  logic        scsi_q, scsi_d;
  logic        reg_q, reg_d;
  logic        read_lat_q, read_lat_d;
  logic        dtack_n_q, dtack_n_d;
  logic        clear_all;
  logic        bar_hit, id_hit, reg_hit, scsi_hit, ack;
  logic        unused_addr_bits;

  // A17..A8 play no part in the decode.
  assign unused_addr_bits = ^ADDR[9:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fcs_meta_q <= 1'b1;
      fcs_s_q    <= 1'b1;
    end else begin
      fcs_meta_q <= FCS_n;
      fcs_s_q    <= fcs_meta_q;
    end
  end

  // addr_q holds A31..A18: [13:6] is the base byte, [5:0] is A23..A18.
  assign bar_hit  = configured && (addr_q[13:6] == bar);
  assign id_hit   = (addr_q[5:0] == IDREG_MATCH);
  assign reg_hit  = (addr_q[5:2] == REG_MATCH);
  assign scsi_hit = ~addr_q[5];
  assign ack      = (idreg_q & sid_dtack) | (reg_q & reg_dtack) | (scsi_q & scsi_dtack);

`ifdef SLAVE_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       berr_n_q, berr_n_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q    <= '0;
      berr_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      berr_n_q <= berr_n_d;
    end
  end

  assign BERR_n = berr_n_q;
`else
  assign BERR_n = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      slave_q    <= 1'b0;
      idreg_q    <= 1'b0;
      scsi_q     <= 1'b0;
      reg_q      <= 1'b0;
      read_lat_q <= 1'b0;
      dtack_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      slave_q    <= slave_d;
      idreg_q    <= idreg_d;
      scsi_q     <= scsi_d;
      reg_q      <= reg_d;
      read_lat_q <= read_lat_d;
      dtack_n_q  <= dtack_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    slave_d    = slave_q;
    idreg_d    = idreg_q;
    scsi_d     = scsi_q;
    reg_d      = reg_q;
    read_lat_d = read_lat_q;
    dtack_n_d  = dtack_n_q;
    clear_all  = 1'b0;
`ifdef SLAVE_TIMEOUT_EN
    cnt_d      = cnt_q;
    berr_n_d   = berr_n_q;
`endif

    case (state_q)
      StIdle: begin
        if (!fcs_s_q) begin
          addr_d  = ADDR[23:10];
          rd_d    = READ;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (fcs_s_q) begin
          clear_all = 1'b1;
        end else if (bar_hit && (id_hit || reg_hit || scsi_hit)) begin
          slave_d    = 1'b1;
          read_lat_d = rd_q;
          idreg_d    = id_hit;
          reg_d      = ~id_hit & reg_hit;
          scsi_d     = ~id_hit & ~reg_hit & scsi_hit;
          state_d    = StActive;
`ifdef SLAVE_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          state_d = StWaitEnd;
        end
      end
      StActive: begin
        if (fcs_s_q) begin
          clear_all = 1'b1;
        end else if (ack) begin
          dtack_n_d = 1'b0;
          state_d   = StAck;
        end else begin
`ifdef SLAVE_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutCnt) begin
            berr_n_d = 1'b0;
            state_d  = StAck;
          end
`endif
        end
      end
      StAck: begin
        if (fcs_s_q) clear_all = 1'b1;
      end
      StWaitEnd: begin
        if (fcs_s_q) state_d = StIdle;
      end
      default: clear_all = 1'b1;
    endcase

    if (clear_all) begin
      state_d    = StIdle;
      slave_d    = 1'b0;
      idreg_d    = 1'b0;
      scsi_d     = 1'b0;
      reg_d      = 1'b0;
      read_lat_d = 1'b0;
      dtack_n_d  = 1'b1;
`ifdef SLAVE_TIMEOUT_EN
      berr_n_d   = 1'b1;
`endif
    end
  end

  assign slave_cycle  = slave_q;
  assign idreg_region = idreg_q;
  assign scsi_region  = scsi_q;
  assign reg_region   = reg_q;
  assign read_lat     = read_lat_q;
  assign DTACK_n      = dtack_n_q;

endmodule

// File: tb/tb_z3_slave_decode.sv
// Scoreboard bench for z3_slave_decode: stimulus queues expected output changes with their
// cycle numbers; a monitor pops and compares every time the output vector changes.
module tb_z3_slave_decode;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FCS_n = 1'b1;
  logic [23:0] ADDR = '0;
  logic        READ = 1'b0;
  logic        configured = 1'b1;
  logic [7:0]  bar = 8'h40;
  logic        sid_dtack = 1'b0;
  logic        scsi_dtack = 1'b0;
  logic        reg_dtack = 1'b0;
  logic        slave_cycle, idreg_region, scsi_region, reg_region, read_lat, DTACK_n, BERR_n;

  z3_slave_decode #(.TIMEOUT_CYCLES(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FCS_n        (FCS_n),
    .ADDR         (ADDR),
    .READ         (READ),
    .configured   (configured),
    .bar          (bar),
    .sid_dtack    (sid_dtack),
    .scsi_dtack   (scsi_dtack),
    .reg_dtack    (reg_dtack),
    .slave_cycle  (slave_cycle),
    .idreg_region (idreg_region),
    .scsi_region  (scsi_region),
    .reg_region   (reg_region),
    .read_lat     (read_lat),
    .DTACK_n      (DTACK_n),
    .BERR_n       (BERR_n)
  );

  always #5 CLK = ~CLK;

  // {slave_cycle, idreg, scsi, reg, read_lat, DTACK_n, BERR_n}
  localparam logic [6:0] Idle = 7'b0000011;
  localparam logic [2:0] RgId = 3'b100, RgScsi = 3'b010, RgReg = 3'b001, RgNone = 3'b000;

  typedef struct packed {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       mon_en = 1'b0;
  logic [6:0] prev_vec = Idle;
  logic [6:0] out_vec;

  assign out_vec = {slave_cycle, idreg_region, scsi_region, reg_region, read_lat, DTACK_n, BERR_n};

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en && (out_vec !== prev_vec)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d act=%b req=%b", cyc, out_vec, prev_vec);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== out_vec) begin
          failures++;
          $display("FAIL out_change act cyc=%0d vec=%b req cyc=%0d vec=%b",
                   cyc, out_vec, e.cyc, e.vec);
        end
      end
      prev_vec = out_vec;
    end
  end

  task automatic push(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%b req=%b", nm, act, req);
    end
  endtask

  // acks = {sid, scsi, reg}, pulsed for one clock once the cycle is in ACTIVE.
  task automatic xact(input logic [23:0] a, input logic rd, input logic [2:0] regn,
                      input logic [2:0] acks, input logic ack_exp);
    int k;
    k = cyc;
    ADDR  = a;
    READ  = rd;
    FCS_n = 1'b0;
    if (regn != RgNone) push(k + 4, {1'b1, regn, rd, 2'b11});
    wait_cyc(5);
    {sid_dtack, scsi_dtack, reg_dtack} = acks;
    if (regn != RgNone && ack_exp) push(k + 6, {1'b1, regn, rd, 2'b01});
    wait_cyc(1);
    {sid_dtack, scsi_dtack, reg_dtack} = 3'b000;
    wait_cyc(2);
    FCS_n = 1'b1;
    if (regn != RgNone) push(k + 11, Idle);
    wait_cyc(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #2 RESET = 1'b1;
    #1 chk("reset_vec", out_vec, Idle);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    mon_en = 1'b1;
    wait_cyc(2);

    xact(24'h408C00, 1'b1, RgId, 3'b100, 1'b1);
    xact(24'h410000, 1'b1, RgNone, 3'b100, 1'b0);
    configured = 1'b0;
    xact(24'h408C00, 1'b1, RgNone, 3'b100, 1'b0);
    configured = 1'b1;
    xact(24'h408000, 1'b0, RgReg, 3'b110, 1'b0);
    xact(24'h408000, 1'b0, RgReg, 3'b001, 1'b1);
    xact(24'h401234, 1'b1, RgScsi, 3'b101, 1'b0);
    xact(24'h401234, 1'b1, RgScsi, 3'b010, 1'b1);
    xact(24'h40C000, 1'b0, RgNone, 3'b111, 1'b0);

    // Aborted cycle, then a normal one two clocks later.
    k = cyc;
    ADDR = 24'h408C00; READ = 1'b1; FCS_n = 1'b0;
    push(k + 4, {1'b1, RgId, 1'b1, 2'b11});
    wait_cyc(5);
    FCS_n = 1'b1;
    push(k + 8, Idle);
    wait_cyc(3);
    wait_cyc(2);
    xact(24'h408C00, 1'b0, RgId, 3'b100, 1'b1);

    // No acknowledge: timeout error if built in, otherwise the cycle just waits.
    k = cyc;
    ADDR = 24'h401234; READ = 1'b0; FCS_n = 1'b0;
    push(k + 4, {1'b1, RgScsi, 1'b0, 2'b11});
`ifdef SLAVE_TIMEOUT_EN
    push(k + 12, {1'b1, RgScsi, 1'b0, 2'b10});
`endif
    wait_cyc(20);
    chk("wait_slave_held", {6'b0, slave_cycle}, 7'd1);
`ifndef SLAVE_TIMEOUT_EN
    chk("wait_berr_idle", {6'b0, BERR_n}, 7'd1);
`endif
    FCS_n = 1'b1;
    push(k + 23, Idle);
    wait_cyc(4);

    // Asynchronous reset while acknowledging.
    k = cyc;
    ADDR = 24'h408000; READ = 1'b0; FCS_n = 1'b0;
    push(k + 4, {1'b1, RgReg, 1'b0, 2'b11});
    wait_cyc(5);
    reg_dtack = 1'b1;
    push(k + 6, {1'b1, RgReg, 1'b0, 2'b01});
    wait_cyc(1);
    reg_dtack = 1'b0;
    wait_cyc(1);
    RESET = 1'b1;
    FCS_n = 1'b1;
    push(k + 7, Idle);
    #1;
    chk("async_rst_dtack", {6'b0, DTACK_n}, 7'd1);
    chk("async_rst_slave", {6'b0, slave_cycle}, 7'd0);
    wait_cyc(2);
    RESET = 1'b0;
    wait_cyc(3);
    xact(24'h401234, 1'b1, RgScsi, 3'b010, 1'b1);

    wait_cyc(3);
    chk("queue_drained", 7'(exp_q.size()), 7'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
